// File: rtl/dpe_sram_arbiter.sv
// Single-port SRAM arbiter for the DPE: scan loader (0), SPI host (1), core (2).
// One registered SRAM access per IDLE->ISSUE->RESP pass; scan first, SPI/core round-robin.
module dpe_sram_arbiter #(
    parameter int SRAM_WORD_LENGTH = 32,
    parameter int SRAM_ADDR_WIDTH  = 8
) (
    input  logic                          CLK,
    input  logic                          RESETn,
    input  logic                          init_done,
    input  logic [2:0]                    req_i,
    input  logic [2:0]                    we_i,
    input  logic [3*SRAM_ADDR_WIDTH-1:0]  addr_i,
    input  logic [3*SRAM_WORD_LENGTH-1:0] wdata_i,
    output logic [2:0]                    ack_o,
    output logic [SRAM_WORD_LENGTH-1:0]   rdata_o,
    output logic                          sram_cs,
    output logic                          sram_we,
    output logic [SRAM_ADDR_WIDTH-1:0]    sram_addr,
    output logic [SRAM_WORD_LENGTH-1:0]   sram_wdata,
    input  logic [SRAM_WORD_LENGTH-1:0]   sram_rdata,
    output logic                          busy_o,
    output logic [1:0]                    grant_id_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t                        state_reg, state_next;
    logic                          rr_core_reg, rr_core_next;
    logic [1:0]                    grant_reg, grant_next;
    logic                          cs_reg, cs_next;
    logic                          we_reg, we_next;
    logic [SRAM_ADDR_WIDTH-1:0]    addr_reg, addr_next;
    logic [SRAM_WORD_LENGTH-1:0]   wdata_reg, wdata_next;

    logic [2:0]                    eligible;
    logic [1:0]                    pick;
    logic [SRAM_ADDR_WIDTH-1:0]    addr_arr  [3];
    logic [SRAM_WORD_LENGTH-1:0]   wdata_arr [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_unpack
        assign addr_arr[gi]  = addr_i[gi*SRAM_ADDR_WIDTH +: SRAM_ADDR_WIDTH];
        assign wdata_arr[gi] = wdata_i[gi*SRAM_WORD_LENGTH +: SRAM_WORD_LENGTH];
    end

    // Core requests stay invisible until the scan loader has finished init.
    assign eligible = req_i & {init_done, 2'b11};

    always_comb begin
        pick = 2'd0;
        if (eligible[0]) begin
            pick = 2'd0;
        end else if (eligible[1] && eligible[2]) begin
            pick = rr_core_reg ? 2'd2 : 2'd1;
        end else if (eligible[1]) begin
            pick = 2'd1;
        end else begin
            pick = 2'd2;
        end
    end

    always_comb begin
        state_next   = state_reg;
        rr_core_next = rr_core_reg;
        grant_next   = grant_reg;
        cs_next      = cs_reg;
        we_next      = we_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        case (state_reg)
            ST_IDLE: begin
                if (|eligible) begin
                    state_next = ST_ISSUE;
                    grant_next = pick;
                    cs_next    = 1'b1;
                    we_next    = we_i[pick];
                    addr_next  = addr_arr[pick];
                    wdata_next = wdata_arr[pick];
                    // Scan grants leave the SPI/core fairness pointer untouched.
                    if (pick != 2'd0) begin
                        rr_core_next = (pick == 2'd1);
                    end
                end
            end
            ST_ISSUE: begin
                state_next = ST_RESP;
                cs_next    = 1'b0;
                we_next    = 1'b0;
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_reg   <= ST_IDLE;
            rr_core_reg <= 1'b0;
            grant_reg   <= 2'd0;
            cs_reg      <= 1'b0;
            we_reg      <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            rr_core_reg <= rr_core_next;
            grant_reg   <= grant_next;
            cs_reg      <= cs_next;
            we_reg      <= we_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
        end
    end

    assign sram_cs    = cs_reg;
    assign sram_we    = we_reg;
    assign sram_addr  = addr_reg;
    assign sram_wdata = wdata_reg;
    assign grant_id_o = grant_reg;
    assign busy_o     = (state_reg != ST_IDLE);
    assign ack_o      = (state_reg == ST_RESP) ? (3'b001 << grant_reg) : 3'b000;
    assign rdata_o    = (state_reg == ST_RESP) ? sram_rdata : '0;

endmodule

// File: tb/tb_dpe_sram_arbiter.sv
// Bench for dpe_sram_arbiter: behavioural SRAM, vector table, scoreboard of expected acks.
module tb_dpe_sram_arbiter;
    localparam int AW = 8;
    localparam int DW = 32;

    logic            CLK = 1'b0;
    logic            RESETn = 1'b0;
    logic            init_done = 1'b0;
    logic [2:0]      req_i = '0;
    logic [2:0]      we_i = '0;
    logic [3*AW-1:0] addr_i = '0;
    logic [3*DW-1:0] wdata_i = '0;
    logic [2:0]      ack_o;
    logic [DW-1:0]   rdata_o;
    logic            sram_cs;
    logic            sram_we;
    logic [AW-1:0]   sram_addr;
    logic [DW-1:0]   sram_wdata;
    logic [DW-1:0]   sram_rdata = '0;
    logic            busy_o;
    logic [1:0]      grant_id_o;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    dpe_sram_arbiter #(.SRAM_WORD_LENGTH(DW), .SRAM_ADDR_WIDTH(AW)) dut (
        .CLK(CLK), .RESETn(RESETn), .init_done(init_done),
        .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .ack_o(ack_o), .rdata_o(rdata_o),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .busy_o(busy_o), .grant_id_o(grant_id_o)
    );

    // Behavioural single-port SRAM, read data one cycle after the cs cycle
    logic [DW-1:0] mem [256];
    always @(posedge CLK) begin
        if (sram_cs) begin
            if (sram_we) mem[sram_addr] <= sram_wdata;
            else         sram_rdata     <= mem[sram_addr];
        end
    end

    typedef struct {
        logic [2:0]    ack;
        logic          rd;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int            k;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          init;
        logic [DW-1:0] exp_rd;
    } vec_t;
    vec_t vt[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input logic rd, input logic [DW-1:0] data);
        exp_t e;
        e.ack  = 3'b001 << k;
        e.rd   = rd;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic wait_ack(input int limit, output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (ack_o == 3'b000 && n < limit);
        if (ack_o == 3'b000) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout actual=none required=ack within %0d cycles", limit);
        end
    endtask

    // Scoreboard: every ack pops one expectation; rdata must be zero between acks
    always @(negedge CLK) begin
        if (ack_o !== 3'b000) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack actual=%b required=000", ack_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_ack", 64'(ack_o), 64'(e.ack));
                if (e.rd) chk("sb_rdata", 64'(rdata_o), 64'(e.data));
                $display("txn ack=%b grant=%0d rdata=%08h", ack_o, grant_id_o, rdata_o);
            end
        end else begin
            chk("rdata_zero", 64'(rdata_o), 64'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic seen;
        int order[3];

        vt[0] = '{0, 1'b1, 8'h20, 32'h000000FF, 1'b0, 32'h0};
        vt[1] = '{1, 1'b0, 8'h20, 32'h0,        1'b0, 32'h000000FF};
        vt[2] = '{1, 1'b1, 8'hFF, 32'hDEADBEEF, 1'b0, 32'h0};
        vt[3] = '{0, 1'b0, 8'hFF, 32'h0,        1'b0, 32'hDEADBEEF};
        vt[4] = '{2, 1'b1, 8'h00, 32'h12345678, 1'b1, 32'h0};
        vt[5] = '{1, 1'b0, 8'h00, 32'h0,        1'b1, 32'h12345678};
        vt[6] = '{2, 1'b0, 8'h20, 32'h0,        1'b1, 32'h000000FF};

        // Reset and idle
        tick(3);
        chk("reset_cs", 64'(sram_cs), 64'd0);
        RESETn = 1'b1;
        tick(2);
        chk("idle_cs", 64'(sram_cs), 64'd0);
        chk("idle_ack", 64'(ack_o), 64'd0);
        chk("idle_busy", 64'(busy_o), 64'd0);
        chk("idle_grant", 64'(grant_id_o), 64'd0);
        chk("idle_rdata", 64'(rdata_o), 64'd0);

        // Single transactions from the vector table, exact cycle checks
        foreach (vt[i]) begin
            init_done = vt[i].init;
            req_i     = 3'b001 << vt[i].k;
            we_i      = 3'b000;
            we_i[vt[i].k] = vt[i].we;
            addr_i[vt[i].k*AW +: AW]  = vt[i].addr;
            wdata_i[vt[i].k*DW +: DW] = vt[i].wdata;
            push(vt[i].k, !vt[i].we, vt[i].exp_rd);
            tick(1);
            chk("vec_cs", 64'(sram_cs), 64'd1);
            chk("vec_we", 64'(sram_we), 64'(vt[i].we));
            chk("vec_addr", 64'(sram_addr), 64'(vt[i].addr));
            if (vt[i].we) chk("vec_wdata", 64'(sram_wdata), 64'(vt[i].wdata));
            chk("vec_grant", 64'(grant_id_o), 64'(vt[i].k));
            chk("vec_busy", 64'(busy_o), 64'd1);
            tick(1);
            chk("vec_resp_cs", 64'(sram_cs), 64'd0);
            chk("vec_ack", 64'(ack_o), 64'(3'b001 << vt[i].k));
            req_i = 3'b000;
            tick(1);
            chk("vec_idle_busy", 64'(busy_o), 64'd0);
        end

        // Core gating while init_done is low
        init_done = 1'b0;
        we_i = 3'b000;
        addr_i[2*AW +: AW] = 8'h00;
        req_i = 3'b100;
        seen = 1'b0;
        repeat (10) begin
            tick(1);
            if (sram_cs || busy_o) seen = 1'b1;
        end
        chk("gate_no_access", 64'(seen), 64'd0);
        init_done = 1'b1;
        push(2, 1'b1, 32'h12345678);
        wait_ack(10, n);
        chk("gate_latency", 64'(n), 64'd2);
        req_i = 3'b000;
        tick(1);

        // Round-robin from reset: SPI first, strict alternation, acks 3 cycles apart
        RESETn = 1'b0;
        tick(2);
        RESETn = 1'b1;
        addr_i[1*AW +: AW] = 8'h20;
        addr_i[2*AW +: AW] = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) push(1, 1'b1, 32'h000000FF);
            else            push(2, 1'b1, 32'hDEADBEEF);
        end
        req_i = 3'b110;
        for (int i = 0; i < 6; i++) begin
            wait_ack(10, n);
            chk("rr_grant", 64'(grant_id_o), 64'((i % 2 == 0) ? 1 : 2));
            chk("rr_interval", 64'(n), 64'((i == 0) ? 2 : 3));
        end
        req_i = 3'b000;
        tick(1);

        // Scan priority, then SPI before core (pointer untouched by the scan grant)
        addr_i[0 +: AW] = 8'h00;
        push(0, 1'b1, 32'h12345678);
        push(1, 1'b1, 32'h000000FF);
        push(2, 1'b1, 32'hDEADBEEF);
        order = '{0, 1, 2};
        req_i = 3'b111;
        for (int i = 0; i < 3; i++) begin
            wait_ack(10, n);
            chk("prio_grant", 64'(grant_id_o), 64'(order[i]));
            req_i[order[i]] = 1'b0;
        end
        tick(1);

        // Reset during ISSUE aborts the access; retry wins the SPI/core tie
        we_i = 3'b010;
        addr_i[1*AW +: AW] = 8'h31;
        wdata_i[1*DW +: DW] = 32'hA5A5A5A5;
        req_i = 3'b010;
        tick(1);
        chk("abort_issue_cs", 64'(sram_cs), 64'd1);
        RESETn = 1'b0;
        tick(1);
        chk("abort_cs", 64'(sram_cs), 64'd0);
        chk("abort_busy", 64'(busy_o), 64'd0);
        chk("abort_ack", 64'(ack_o), 64'd0);
        RESETn = 1'b1;
        addr_i[2*AW +: AW] = 8'h31;
        push(1, 1'b0, 32'h0);
        push(2, 1'b1, 32'hA5A5A5A5);
        req_i = 3'b110;
        wait_ack(10, n);
        chk("retry_grant", 64'(grant_id_o), 64'd1);
        chk("retry_latency", 64'(n), 64'd2);
        req_i[1] = 1'b0;
        wait_ack(10, n);
        chk("retry_core_grant", 64'(grant_id_o), 64'd2);
        chk("retry_core_interval", 64'(n), 64'd3);
        req_i = 3'b000;
        tick(3);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
